load_align_unit: RTL and testbench

Sequential, parametrised load path between the core's memory stage and the data-memory port. Accepts one load request at a time: byte address plus RV `func3`. Issues one or two beat-aligned memory reads, extracts the addressed bytes, and returns a sign- or zero-extended result to writeback. Generalises the combinational load filter with these additions:
- XLEN 32/64, including `ld` and `lwu`
- Valid/ready handshakes
- Misaligned-load splitting across beats

---
 rtl/load_align_unit_if.sv | 46 ++++
 rtl/load_align_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_align_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// ----------------------------------------------------------------------------
// load_align_unit_if
// Bundles the three handshake channels of the load alignment unit.
//   request  : req_valid/req_ready, req_addr, req_func3    (core -> unit)
//   memory   : mem_req_valid/mem_req_ready, mem_addr        (unit -> memory)
//              mem_rvalid, mem_rdata                        (memory -> unit)
//   response : resp_valid/resp_ready, resp_data, resp_err   (unit -> writeback)
// Modports: slave  = the load unit's view
//           master = the surrounding system's view (core + memory + writeback)
// ----------------------------------------------------------------------------
interface load_align_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_func3;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic              resp_err;

   modport slave (
      input  req_valid, req_addr, req_func3,
      input  mem_req_ready, mem_rvalid, mem_rdata,
      input  resp_ready,
      output req_ready, mem_req_valid, mem_addr,
      output resp_valid, resp_data, resp_err
   );

   modport master (
      output req_valid, req_addr, req_func3,
      output mem_req_ready, mem_rvalid, mem_rdata,
      output resp_ready,
      input  req_ready, mem_req_valid, mem_addr,
      input  resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/load_align_unit.sv
// ----------------------------------------------------------------------------
// load_align_unit
// Sequential load path between the memory stage and the data-memory port.
// Takes one load (byte address + RV func3) at a time, reads one or two
// beat-aligned words, extracts the addressed bytes and returns them sign- or
// zero-extended.
//
// Parameters : XLEN   (32 or 64) data / beat width
//              ADDR_W byte-address width
// Ports      : clk, rst_n (asynchronous, active low)
//              bus    load_align_unit_if.slave (request, memory, response)
// Build option: define LOAD_SPLIT_EN to split loads that cross a beat
//              boundary into two reads; without it any load not aligned to
//              its size is answered with resp_err and no memory access.
// ----------------------------------------------------------------------------
module load_align_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   load_align_unit_if.slave bus
);
   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ0  = 3'd1;
   localparam logic [2:0] WAIT0 = 3'd2;
`ifdef LOAD_SPLIT_EN
   localparam logic [2:0] REQ1  = 3'd3;
   localparam logic [2:0] WAIT1 = 3'd4;
`endif
   localparam logic [2:0] RESP  = 3'd5;

   logic [2:0]        state;
   logic [OFF_W-1:0]  offset_q;
   logic [2:0]        func3_q;
   logic              mem_req_valid_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [XLEN-1:0]   resp_data_q;

   logic [OFF_W-1:0]  req_off;
   logic              req_bad;
   logic [XLEN-1:0]   beat_lo;
   logic [XLEN-1:0]   beat_hi;
   logic [XLEN-1:0]   assembled;

   assign req_off = bus.req_addr[OFF_W-1:0];

`ifdef LOAD_SPLIT_EN
   logic [XLEN-1:0]   beat0_q;
   logic [4:0]        span;
   logic              crosses;

   // Last byte touched lies past the end of the first beat -> second read.
   assign span    = 5'(offset_q) + (5'd1 << func3_q[1:0]);
   assign crosses = span > 5'(BYTES);
`else
   logic [3:0]        req_size;

   assign req_size = 4'd1 << bus.req_func3[1:0];
`endif

   // Requests answered straight from IDLE with an error, no memory traffic.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      req_bad = (bus.req_func3 == 3'b111);
      if (XLEN == 32 && (bus.req_func3 == 3'b011 || bus.req_func3 == 3'b110))
         req_bad = 1'b1;
`ifndef LOAD_SPLIT_EN
      if ((req_off & OFF_W'(req_size - 4'd1)) != '0)
         req_bad = 1'b1;
`endif
   end

   // Shift {hi, lo} down to the addressed byte, keep the access size, extend.
   function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0]  lo,
                                               input logic [XLEN-1:0]  hi,
                                               input logic [OFF_W-1:0] off,
                                               input logic [2:0]       f3);
      logic [XLEN-1:0] raw;
      logic [XLEN-1:0] mask;
      logic            sign;
      raw  = XLEN'({hi, lo} >> {off, 3'b000});
      mask = '1;
      sign = 1'b0;
      case (f3[1:0])
         2'b00:   begin mask = XLEN'(8'hFF);         sign = raw[7];  end
         2'b01:   begin mask = XLEN'(16'hFFFF);      sign = raw[15]; end
         2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); sign = raw[31]; end
         default: ;
      endcase
      if (f3[2])
         sign = 1'b0;
      return (raw & mask) | (sign ? ~mask : '0);
   endfunction

   always_comb begin
      beat_lo = bus.mem_rdata;
      beat_hi = '0;
`ifdef LOAD_SPLIT_EN
      if (state == WAIT1) begin
         beat_lo = beat0_q;
         beat_hi = bus.mem_rdata;
      end
`endif
   end

   assign assembled = extract(beat_lo, beat_hi, offset_q, func3_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         offset_q        <= '0;
         func3_q         <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         resp_valid_q    <= 1'b0;
         resp_err_q      <= 1'b0;
         resp_data_q     <= '0;
`ifdef LOAD_SPLIT_EN
         beat0_q         <= '0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  offset_q <= req_off;
                  func3_q  <= bus.req_func3;
                  if (req_bad) begin
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= '0;
                  end else begin
                     state           <= REQ0;
                     mem_req_valid_q <= 1'b1;
                     mem_addr_q      <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  end
               end
            end
            REQ0: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state           <= WAIT0;
               end
            end
            WAIT0: begin
               if (bus.mem_rvalid) begin
`ifdef LOAD_SPLIT_EN
                  if (crosses) begin
                     beat0_q         <= bus.mem_rdata;
                     mem_addr_q      <= mem_addr_q + ADDR_W'(BYTES);
                     mem_req_valid_q <= 1'b1;
                     state           <= REQ1;
                  end else begin
                     resp_data_q  <= assembled;
                     resp_err_q   <= 1'b0;
                     resp_valid_q <= 1'b1;
                     state        <= RESP;
                  end
`else
                  resp_data_q  <= assembled;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state        <= RESP;
`endif
               end
            end
`ifdef LOAD_SPLIT_EN
            REQ1: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state           <= WAIT1;
               end
            end
            WAIT1: begin
               if (bus.mem_rvalid) begin
                  resp_data_q  <= assembled;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state        <= RESP;
               end
            end
`endif
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (state == IDLE);
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_err      = resp_err_q;
   assign bus.resp_data     = resp_data_q;
endmodule

// File: tb/tb_load_align_unit.sv
// ----------------------------------------------------------------------------
// tb_load_align_unit
// Drives an XLEN=32 and an XLEN=64 instance of load_align_unit from one shared
// set of stimulus signals; `sel` picks which instance is live. Expected
// responses go into a scoreboard queue when a load is issued and a monitor
// pops and compares them at each response handshake. Expectations follow the
// LOAD_SPLIT_EN build option.
// ----------------------------------------------------------------------------
module tb_load_align_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

   load_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   load_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_func3 = '0;
   logic        mem_req_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        resp_ready = 1'b0;

   assign b32.req_valid     = req_valid & ~sel;
   assign b32.req_addr      = req_addr;
   assign b32.req_func3     = req_func3;
   assign b32.mem_req_ready = mem_req_ready & ~sel;
   assign b32.mem_rvalid    = mem_rvalid & ~sel;
   assign b32.mem_rdata     = mem_rdata[31:0];
   assign b32.resp_ready    = resp_ready & ~sel;

   assign b64.req_valid     = req_valid & sel;
   assign b64.req_addr      = req_addr;
   assign b64.req_func3     = req_func3;
   assign b64.mem_req_ready = mem_req_ready & sel;
   assign b64.mem_rvalid    = mem_rvalid & sel;
   assign b64.mem_rdata     = mem_rdata;
   assign b64.resp_ready    = resp_ready & sel;

   logic        o_req_ready, o_mem_req_valid, o_resp_valid, o_resp_err;
   logic [31:0] o_mem_addr;
   logic [63:0] o_resp_data;
   assign o_req_ready     = sel ? b64.req_ready     : b32.req_ready;
   assign o_mem_req_valid = sel ? b64.mem_req_valid : b32.mem_req_valid;
   assign o_mem_addr      = sel ? b64.mem_addr      : b32.mem_addr;
   assign o_resp_valid    = sel ? b64.resp_valid    : b32.resp_valid;
   assign o_resp_err      = sel ? b64.resp_err      : b32.resp_err;
   assign o_resp_data     = sel ? b64.resp_data     : {32'd0, b32.resp_data};

   typedef struct packed {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && o_resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            check("resp without request", 64'(o_resp_valid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_err", 64'(o_resp_err), 64'(mon_e.err));
            check("resp_data", o_resp_data, mon_e.data);
         end
      end
   end

   // One load: issues it, plays the memory, holds off ready as asked and
   // checks addresses, latency, beat count and held data along the way.
   task automatic run(input string name, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [63:0] b0, input logic [63:0] b1,
                      input logic [31:0] a0, input logic [31:0] a1, input int n_beats,
                      input logic exp_err, input logic [63:0] exp_data, input int exp_lat,
                      input int req_stall, input int resp_stall);
      int beats = 0;
      int stall = 0;
      int hold  = 0;
      int lat   = 0;
      int cyc   = 1;
      bit rv_pend = 1'b0;
      bit done    = 1'b0;
      exp_q.push_back('{err: exp_err, data: exp_data});
      check({name, " req_ready"}, 64'(o_req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_func3 = f3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (!done && cyc <= 40) begin
         mem_rvalid = rv_pend;
         mem_rdata  = rv_pend ? ((beats == 1) ? b0 : b1) : 64'd0;
         rv_pend    = 1'b0;
         mem_req_ready = 1'b0;
         if (o_mem_req_valid) begin
            check({name, " mem_addr"}, 64'(o_mem_addr), 64'((beats == 0) ? a0 : a1));
            if (stall < req_stall) begin
               stall++;
            end else begin
               mem_req_ready = 1'b1;
               beats++;
               rv_pend = 1'b1;
            end
         end
         resp_ready = 1'b0;
         if (o_resp_valid) begin
            if (lat == 0) begin
               lat = cyc;
               check({name, " latency"}, 64'(lat), 64'(exp_lat));
            end
            check({name, " resp_data held"}, o_resp_data, exp_data);
            if (hold < resp_stall) begin
               hold++;
            end else begin
               resp_ready = 1'b1;
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      mem_rvalid    = 1'b0;
      mem_req_ready = 1'b0;
      resp_ready    = 1'b0;
      check({name, " completed"}, 64'(done), 64'd1);
      check({name, " beats"}, 64'(beats), 64'(n_beats));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("reset mem_req_valid", 64'(b32.mem_req_valid), 64'd0);
      check("reset resp_valid", 64'(b32.resp_valid), 64'd0);
      check("reset resp_err", 64'(b32.resp_err), 64'd0);
      check("reset resp_data", 64'(b32.resp_data), 64'd0);
      check("reset mem_addr", 64'(b32.mem_addr), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---------------- XLEN = 32 ----------------
      sel = 1'b0;
      run("lb 103", 32'h103, 3'b000, 64'h80FF_0000, 64'h0, 32'h100, 32'h0, 1,
          1'b0, 64'hFFFF_FF80, 3, 0, 0);
      run("lhu 102", 32'h102, 3'b101, 64'hBEEF_1234, 64'h0, 32'h100, 32'h0, 1,
          1'b0, 64'h0000_BEEF, 3, 0, 0);
      run("lh 102", 32'h102, 3'b001, 64'hBEEF_1234, 64'h0, 32'h100, 32'h0, 1,
          1'b0, 64'hFFFF_BEEF, 3, 0, 0);
`ifdef LOAD_SPLIT_EN
      run("lw 0FE split", 32'h0FE, 3'b010, 64'hAABB_CCDD, 64'h1122_3344, 32'h0FC, 32'h100, 2,
          1'b0, 64'h3344_AABB, 5, 0, 0);
      run("lh 101 inbeat", 32'h101, 3'b001, 64'h00AB_CD00, 64'h0, 32'h100, 32'h0, 1,
          1'b0, 64'hFFFF_ABCD, 3, 0, 0);
      run("lh wrap", 32'hFFFF_FFFF, 3'b001, 64'h1200_0000, 64'h0000_0034, 32'hFFFF_FFFC,
          32'h0, 2, 1'b0, 64'h3412, 5, 0, 0);
`else
      run("lw 0FE misaligned", 32'h0FE, 3'b010, 64'hAABB_CCDD, 64'h1122_3344, 32'h0, 32'h0, 0,
          1'b1, 64'h0, 1, 0, 0);
      run("lh 101 misaligned", 32'h101, 3'b001, 64'h00AB_CD00, 64'h0, 32'h0, 32'h0, 0,
          1'b1, 64'h0, 1, 0, 0);
      run("lh wrap misaligned", 32'hFFFF_FFFF, 3'b001, 64'h1200_0000, 64'h34, 32'h0, 32'h0, 0,
          1'b1, 64'h0, 1, 0, 0);
`endif
      run("lbu 101", 32'h101, 3'b100, 64'h0000_F100, 64'h0, 32'h100, 32'h0, 1,
          1'b0, 64'h0000_00F1, 3, 0, 0);
      run("ld on rv32", 32'h100, 3'b011, 64'h0, 64'h0, 32'h0, 32'h0, 0, 1'b1, 64'h0, 1, 0, 0);
      run("lwu on rv32", 32'h100, 3'b110, 64'h0, 64'h0, 32'h0, 32'h0, 0, 1'b1, 64'h0, 1, 0, 0);
      run("func3 111", 32'h100, 3'b111, 64'h0, 64'h0, 32'h0, 32'h0, 0, 1'b1, 64'h0, 1, 0, 0);
      run("lw mem stall", 32'h200, 3'b010, 64'h8000_0001, 64'h0, 32'h200, 32'h0, 1,
          1'b0, 64'h8000_0001, 7, 4, 0);
      run("lh resp stall", 32'h3FE, 3'b001, 64'h7FFF_0000, 64'h0, 32'h3FC, 32'h0, 1,
          1'b0, 64'h0000_7FFF, 3, 0, 3);

      // Reset pulsed while waiting for read data; the late rvalid must vanish.
      check("abort req_ready", 64'(o_req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = 32'h104;
      req_func3 = 3'b000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort mem_req_valid", 64'(o_mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort mem_req_valid cleared", 64'(o_mem_req_valid), 64'd0);
      check("abort mem_addr cleared", 64'(o_mem_addr), 64'd0);
      check("abort resp_valid cleared", 64'(o_resp_valid), 64'd0);
      check("abort resp_data cleared", o_resp_data, 64'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h0000_00AA;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("abort no resp", 64'(o_resp_valid), 64'd0);
         check("abort no mem req", 64'(o_mem_req_valid), 64'd0);
         @(posedge clk); #1;
      end

      // ---------------- XLEN = 64 ----------------
      sel = 1'b1;
      #1;
      run("lwu 204", 32'h204, 3'b110, 64'h8765_4321_0000_0000, 64'h0, 32'h200, 32'h0, 1,
          1'b0, 64'h0000_0000_8765_4321, 3, 0, 0);
      run("lw 204", 32'h204, 3'b010, 64'h8765_4321_0000_0000, 64'h0, 32'h200, 32'h0, 1,
          1'b0, 64'hFFFF_FFFF_8765_4321, 3, 0, 0);
      run("ld 208", 32'h208, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h208, 32'h0, 1,
          1'b0, 64'h0123_4567_89AB_CDEF, 3, 0, 0);
      run("lb 20F", 32'h20F, 3'b000, 64'h7F00_0000_0000_0000, 64'h0, 32'h208, 32'h0, 1,
          1'b0, 64'h0000_0000_0000_007F, 3, 0, 0);
      run("func3 111 rv64", 32'h200, 3'b111, 64'h0, 64'h0, 32'h0, 32'h0, 0,
          1'b1, 64'h0, 1, 0, 0);
`ifdef LOAD_SPLIT_EN
      run("ld 20C split", 32'h20C, 3'b011, 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555,
          32'h208, 32'h210, 2, 1'b0, 64'h6666_5555_4444_3333, 5, 0, 0);
`else
      run("ld 20C misaligned", 32'h20C, 3'b011, 64'h4444_3333_2222_1111, 64'h0, 32'h0, 32'h0, 0,
          1'b1, 64'h0, 1, 0, 0);
`endif

      @(posedge clk); #1;
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
